// File: rtl/vga_mode_gen.sv
// VGA timing generator with per-frame colour-format selection.
// Counters run at stage 0; all pixel and sync outputs appear one cycle later.
module vga_mode_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [23:0]   color,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          hs,
  output logic          vs,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          frame_start
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG_X = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END_X = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_ACT_Y  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG_Y = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END_Y = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] BAR_X    = XW'(H_ACTIVE / 8);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    mode_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          hb_q, hb_d, vb_q, vb_d;
  logic          de_q, de_d, fs_q, fs_d;
  logic          h_act, v_act, h_sync, v_sync, frame_end;
  logic [2:0]    bar_k;

  function automatic logic [23:0] expand(input logic [1:0] m, input logic [23:0] c,
                                         input logic [2:0] k);
    logic [23:0] p;
    case (m)
      2'd0:    p = {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
      2'd1:    p = {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
      2'd2:    p = c;
      default: p = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endcase
    return p;
  endfunction

  // Stage 0: raster counters and timing decode
  always_comb begin
    frame_end = (x_q == H_LAST) && (y_q == V_LAST);
    x_d = (x_q == H_LAST) ? '0 : x_q + XW'(1);
    y_d = y_q;
    if (x_q == H_LAST) y_d = (y_q == V_LAST) ? '0 : y_q + YW'(1);
    h_act  = x_q < H_ACT_X;
    v_act  = y_q < V_ACT_Y;
    h_sync = (x_q >= HS_BEG_X) && (x_q < HS_END_X);
    v_sync = (y_q >= VS_BEG_Y) && (y_q < VS_END_Y);
    bar_k  = 3'(x_q / BAR_X);
    de_d   = h_act && v_act;
    hb_d   = ~h_act;
    vb_d   = ~v_act;
    hs_d   = h_sync ? HS_ON : ~HS_ON;
    vs_d   = v_sync ? VS_ON : ~VS_ON;
    fs_d   = (x_q == '0) && (y_q == '0);
    rgb_d  = de_d ? expand(mode_q, color, bar_k) : 24'h0;
  end

  // Stage 1: registered pixel/sync outputs; mode latched only at frame end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= mode;
      rgb_q  <= 24'h0;
      de_q   <= 1'b0;
      hb_q   <= 1'b1;
      vb_q   <= 1'b1;
      fs_q   <= 1'b0;
      hs_q   <= ~HS_ON;
      vs_q   <= ~VS_ON;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      if (frame_end) mode_q <= mode;
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hb_q  <= hb_d;
      vb_q  <= vb_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign hblank      = hb_q;
  assign vblank      = vb_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_mode_gen.sv
// Bench for vga_mode_gen: three parameterisations checked against a raster-position
// reference model, plus vector table and directed mode-switch / reset sequences.
module tb_vga_mode_gen;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [1:0]  mode    = 2'd0;
  logic [23:0] color   = 24'h0;

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic hs, vs, hb, vb, de, fs;
  } outs_t;

  typedef struct {
    logic [1:0]  m;
    logic [23:0] c;
    logic [23:0] rgb;
  } vec_t;

  // instance 0: default, 1: active-high syncs with 320 active, 2: small raster
  logic [9:0] x_def, y_def, y_pol;
  logic [8:0] x_pol;
  logic [5:0] x_sm;
  logic [3:0] y_sm;
  logic [7:0] r_def, g_def, b_def, r_pol, g_pol, b_pol, r_sm, g_sm, b_sm;
  logic hs_def, vs_def, hb_def, vb_def, de_def, fs_def;
  logic hs_pol, vs_pol, hb_pol, vb_pol, de_pol, fs_pol;
  logic hs_sm, vs_sm, hb_sm, vb_sm, de_sm, fs_sm;

  vga_mode_gen u_def (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .color(color),
    .x(x_def), .y(y_def), .r(r_def), .g(g_def), .b(b_def),
    .hs(hs_def), .vs(vs_def), .hblank(hb_def), .vblank(vb_def), .de(de_def),
    .frame_start(fs_def));

  vga_mode_gen #(.H_ACTIVE(320), .HS_POL(1), .VS_POL(1)) u_pol (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .color(color),
    .x(x_pol), .y(y_pol), .r(r_pol), .g(g_pol), .b(b_pol),
    .hs(hs_pol), .vs(vs_pol), .hblank(hb_pol), .vblank(vb_pol), .de(de_pol),
    .frame_start(fs_pol));

  vga_mode_gen #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(4),
                 .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_sm (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .color(color),
    .x(x_sm), .y(y_sm), .r(r_sm), .g(g_sm), .b(b_sm),
    .hs(hs_sm), .vs(vs_sm), .hblank(hb_sm), .vblank(vb_sm), .de(de_sm),
    .frame_start(fs_sm));

  int    HA  [3] = '{640, 320, 32};
  int    HFP [3] = '{16, 16, 4};
  int    HSY [3] = '{96, 96, 6};
  int    HBP [3] = '{48, 48, 4};
  int    VA  [3] = '{480, 480, 6};
  int    VFP [3] = '{10, 10, 1};
  int    VSY [3] = '{2, 2, 2};
  int    VBP [3] = '{33, 33, 2};
  int    HP  [3] = '{0, 1, 0};
  int    VP  [3] = '{0, 1, 0};

  int    dx [3];
  int    dy [3];
  outs_t dout [3];

  always_comb begin
    dx[0] = int'(x_def);
    dx[1] = int'(x_pol);
    dx[2] = int'(x_sm);
    dy[0] = int'(y_def);
    dy[1] = int'(y_pol);
    dy[2] = int'(y_sm);
    dout[0] = {r_def, g_def, b_def, hs_def, vs_def, hb_def, vb_def, de_def, fs_def};
    dout[1] = {r_pol, g_pol, b_pol, hs_pol, vs_pol, hb_pol, vb_pol, de_pol, fs_pol};
    dout[2] = {r_sm, g_sm, b_sm, hs_sm, vs_sm, hb_sm, vb_sm, de_sm, fs_sm};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_pix(input int m, input logic [23:0] c,
                                          input int px, input int ha);
    int k;
    k = px / (ha / 8);
    case (m)
      0:       return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
      1:       return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
      2:       return c;
      default: return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endcase
  endfunction

  // Reference model: raster position as a linear pixel index within the frame
  int    mx [3];
  int    my [3];
  int    mm [3];
  bit    mvalid [3] = '{0, 0, 0};
  outs_t eo [3];

  always @(negedge clk_sys) begin
    int ht, vt, pos;
    outs_t o;
    for (int i = 0; i < 3; i++) begin
      if (mvalid[i]) begin
        chk($sformatf("model_x%0d", i), dx[i], mx[i]);
        chk($sformatf("model_y%0d", i), dy[i], my[i]);
        chk($sformatf("model_out%0d", i), 32'(dout[i]), 32'(eo[i]));
      end
      ht = HA[i] + HFP[i] + HSY[i] + HBP[i];
      vt = VA[i] + VFP[i] + VSY[i] + VBP[i];
      o = '0;
      if (reset) begin
        o.hs = (HP[i] == 0);
        o.vs = (VP[i] == 0);
        o.hb = 1'b1;
        o.vb = 1'b1;
        mx[i] = 0;
        my[i] = 0;
        mm[i] = int'(mode);
        mvalid[i] = 1'b1;
      end else begin
        o.de = (mx[i] < HA[i]) && (my[i] < VA[i]);
        o.hb = !(mx[i] < HA[i]);
        o.vb = !(my[i] < VA[i]);
        o.hs = (mx[i] >= HA[i] + HFP[i] && mx[i] < HA[i] + HFP[i] + HSY[i]) ?
               (HP[i] != 0) : (HP[i] == 0);
        o.vs = (my[i] >= VA[i] + VFP[i] && my[i] < VA[i] + VFP[i] + VSY[i]) ?
               (VP[i] != 0) : (VP[i] == 0);
        o.fs = (mx[i] == 0) && (my[i] == 0);
        if (o.de) {o.r, o.g, o.b} = ref_pix(mm[i], color, mx[i], HA[i]);
        if (mx[i] == ht - 1 && my[i] == vt - 1) mm[i] = int'(mode);
        pos = my[i] * ht + mx[i] + 1;
        mx[i] = pos % ht;
        my[i] = (pos / ht) % vt;
      end
      eo[i] = o;
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset = 1'b1;
    mode  = m;
    step();
    step();
    reset = 1'b0;
  endtask

  vec_t vecs [12];

  initial begin
    int n, hsl, hsf, dec, hph, hpf, pdec, vsl, vsf, sdec, sfs, p;
    outs_t e;

    vecs[0]  = '{2'd0, 24'h0000E0, 24'hFF0000};
    vecs[1]  = '{2'd0, 24'h0000FF, 24'hFFFFFF};
    vecs[2]  = '{2'd0, 24'h00001C, 24'h00FF00};
    vecs[3]  = '{2'd0, 24'h000003, 24'h0000FF};
    vecs[4]  = '{2'd0, 24'h000092, 24'h9292AA};
    vecs[5]  = '{2'd1, 24'h0007E0, 24'h00FF00};
    vecs[6]  = '{2'd1, 24'h00F800, 24'hFF0000};
    vecs[7]  = '{2'd1, 24'h00001F, 24'h0000FF};
    vecs[8]  = '{2'd1, 24'h008410, 24'h848284};
    vecs[9]  = '{2'd2, 24'h123456, 24'h123456};
    vecs[10] = '{2'd2, 24'hABCDEF, 24'hABCDEF};
    vecs[11] = '{2'd3, 24'hFFFFFF, 24'h000000};

    step();
    step();
    e = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1;
    chk("reset_out_def", 32'(dout[0]), 32'(e));
    chk("reset_x_def", dx[0], 0);

    // First pixel of a frame after reset, per colour format
    for (int i = 0; i < 12; i++) begin
      color = vecs[i].c;
      do_reset(vecs[i].m);
      step();
      chk($sformatf("vec%0d_de_fs", i), {30'd0, de_def, fs_def}, 32'd3);
      chk($sformatf("vec%0d_rgb_def", i), {8'd0, r_def, g_def, b_def}, {8'd0, vecs[i].rgb});
      chk($sformatf("vec%0d_rgb_sm", i), {8'd0, r_sm, g_sm, b_sm}, {8'd0, vecs[i].rgb});
    end

    // Timing statistics over one default line and two small frames
    do_reset(2'd2);
    chk("release_x0", dx[0], 0);
    hsl = 0; hsf = -1; dec = 0; hph = 0; hpf = -1; pdec = 0;
    vsl = 0; vsf = -1; sdec = 0; sfs = 0;
    for (int k = 1; k <= 1012; k++) begin
      step();
      color = $urandom;
      p = k - 1;
      if (k <= 800) begin
        if (!hs_def) begin hsl++; if (hsf < 0) hsf = p; end
        if (de_def) dec++;
      end
      if (k <= 480) begin
        if (hs_pol) begin hph++; if (hpf < 0) hpf = p; end
        if (de_pol) pdec++;
      end
      if (!vs_sm) begin vsl++; if (vsf < 0) vsf = p / 46; end
      if (de_sm) sdec++;
      if (fs_sm) sfs++;
      if (k == 800) chk("def_period", {dy[0][15:0], dx[0][15:0]}, {16'd1, 16'd0});
      if (k == 480) chk("pol_period", {dy[1][15:0], dx[1][15:0]}, {16'd1, 16'd0});
    end
    chk("def_hs_low_cnt", hsl, 96);
    chk("def_hs_start", hsf, 656);
    chk("def_de_cnt", dec, 640);
    chk("pol_hs_high_cnt", hph, 96);
    chk("pol_hs_start", hpf, 336);
    chk("pol_de_cnt", pdec, 320);
    chk("sm_vs_low_cnt", vsl, 184);
    chk("sm_vs_line", vsf, 7);
    chk("sm_de_cnt", sdec, 384);
    chk("sm_fs_cnt", sfs, 2);

    // Mid-frame mode switch on the small raster takes effect next frame
    color = 24'h123456;
    do_reset(2'd2);
    n = 0;
    while (y_sm != 4'd3 && n < 600) begin step(); n++; end
    chk("wait_y3", {31'd0, n < 600}, 1);
    mode = 2'd3;
    n = 0;
    while (!de_sm && n < 100) begin step(); n++; end
    chk("wait_de", {31'd0, n < 100}, 1);
    chk("still_888", {8'd0, r_sm, g_sm, b_sm}, 32'h123456);
    n = 0;
    while (!fs_sm && n < 600) begin step(); n++; end
    chk("wait_fs", {31'd0, n < 600}, 1);
    chk("bar0_black", {7'd0, de_sm, r_sm, g_sm, b_sm}, 32'h1000000);
    for (int k = 0; k < 28; k++) step();
    chk("bar7_white", {7'd0, de_sm, r_sm, g_sm, b_sm}, 32'h1FFFFFF);

    // Reset asserted mid-frame
    n = 0;
    while (!(x_sm == 6'd20 && y_sm == 4'd4) && n < 600) begin step(); n++; end
    chk("wait_x20y4", {31'd0, n < 600}, 1);
    reset = 1'b1;
    step();
    chk("midrst_xy_sm", {dy[2][15:0], dx[2][15:0]}, 32'd0);
    chk("midrst_xy_def", {dy[0][15:0], dx[0][15:0]}, 32'd0);
    chk("midrst_out_sm", 32'(dout[2]), 32'(e));
    e.hs = 1'b0; e.vs = 1'b0;
    chk("midrst_out_pol", 32'(dout[1]), 32'(e));
    step();
    step();
    reset = 1'b0;
    chk("rel_x0", dx[2], 0);
    step();
    chk("rel_fs", {30'd0, fs_sm, fs_def}, 32'd3);
    chk("rel_x1", dx[2], 1);

    // Randomised traffic with occasional mode changes and resets
    for (int k = 0; k < 3000; k++) begin
      step();
      color = $urandom;
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 599) == 0);
    end
    reset = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_mode_gen.md
VGA_MODE_GEN -- requirements
Module: vga_mode_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line SHALL be configurable.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48 SHALL set horizontal front porch, sync and back porch in pixels.
REQ-003 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 SHALL set the vertical equivalents in lines.
REQ-004 Parameters HS_POL 0 and VS_POL 0 SHALL set sync active level (0 = active-low).
REQ-005 Derived H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL (same form); XW = clog2(H_TOTAL), YW = clog2(V_TOTAL).
REQ-006 clk_sys  in  1  pixel clock; sole clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 mode  in  2  colour format: 0 RGB332 (color[7:0]), 1 RGB565 (color[15:0]), 2 RGB888, 3 test pattern.
REQ-009 color  in  24  pixel colour for current x/y, LSB-aligned per mode.
REQ-010 x  out  XW  horizontal counter; y  out  YW  vertical counter.
REQ-011 r, g, b  out  8 each  expanded pixel colour.
REQ-012 hs, vs  out  1  sync at programmed polarity; hblank, vblank, de  out  1  blanking and data-enable, active-high.
REQ-013 frame_start  out  1  single-cycle pulse aligned with the first pixel of a frame on r/g/b.

Function
REQ-014 x SHALL increment each cycle, wrapping H_TOTAL-1 -> 0; y SHALL increment on x wrap, wrapping V_TOTAL-1 -> 0.
REQ-015 Stage-0 timing: h_act = x < H_ACTIVE; h_sync = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vertical terms likewise on y.
REQ-016 All of r, g, b, hs, vs, hblank, vblank, de, frame_start SHALL be registered and SHALL lag x/y by exactly 1 cycle.
REQ-017 color SHALL be sampled in the same cycle as the x/y it belongs to.
REQ-018 de = h_act AND v_act; hblank = NOT h_act; vblank = NOT v_act; hs = h_sync XOR NOT HS_POL (vs likewise).
REQ-019 When de = 0, r = g = b = 8'h00.
REQ-020 RGB332 expansion: R = {c[7:5],c[7:5],c[7:6]}, G = {c[4:2],c[4:2],c[4:3]}, B = {c[1:0] repeated 4x}.
REQ-021 RGB565 expansion: R = {c[15:11],c[15:13]}, G = {c[10:5],c[10:9]}, B = {c[4:0],c[4:2]}.
REQ-022 RGB888: R = c[23:16], G = c[15:8], B = c[7:0].
REQ-023 Test pattern: 8 vertical bars of width H_ACTIVE/8 selected by bar index k = 0..7; R = {8{k[2]}}, G = {8{k[1]}}, B = {8{k[0]}}; color ignored.
REQ-024 Active mode SHALL be a register loaded from mode only in the cycle x = H_TOTAL-1 and y = V_TOTAL-1; mode changes mid-frame SHALL NOT affect the current frame.
REQ-025 frame_start SHALL assert when the pixel output for x = 0, y = 0 is presented and SHALL be low otherwise.
REQ-026 Arithmetic SHALL be unsigned; no counter SHALL reach H_TOTAL or V_TOTAL.

Reset
REQ-027 While reset = 1: x = 0, y = 0, r = g = b = 0, de = 0, hblank = vblank = 1, frame_start = 0, hs = vs at inactive level, active mode loaded from mode.
REQ-028 Reset asserted mid-frame SHALL take effect on the next clk_sys edge; first cycle after release SHALL present x = 0, y = 0, with its pixel output and frame_start = 1 one cycle later.

Verification
REQ-029 Default parameters, run 2 frames -> x period 800 cycles, y period 525 lines, hs low for 96 cycles starting x = 656, vs low for lines 490-491, de high for 640x480 per frame.
REQ-030 mode = 0, color = 8'hE0 -> r = 8'hFF, g = 8'h00, b = 8'h00 during de; mode = 0, color = 8'hFF -> r = g = b = 8'hFF.
REQ-031 mode = 1, color = 16'h07E0 -> r = 0, g = 8'hFF, b = 0; mode = 2, color = 24'h123456 -> r = 12, g = 34, b = 56.
REQ-032 Switch mode 2 -> 3 at y = 100 -> output stays RGB888 until frame end; next frame shows bars, x = 0..79 black, x = 560..639 white.
REQ-033 Reset pulse at x = 300, y = 200 -> counters 0 next cycle, frame_start 1 two cycles after release, all outputs at REQ-027 values during reset.
REQ-034 HS_POL = 1, VS_POL = 1, H_ACTIVE = 320 -> hs high only in sync window, x period H_TOTAL = 480, de width 320.
